// File: rtl/xalu_seq_if.sv
// Handshake and operand/result bundle for xalu_seq; master drives requests, slave answers.
interface xalu_seq_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             ready;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             com;
   logic             use_acc;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_hi;
   logic             done;
   logic             co;
   logic             ov;
   logic             zero;
   logic             ones;
   logic             eq;
   logic             err;

   modport master (
      output start, op, a, b, ci, com, use_acc,
      input  ready, y, y_hi, done, co, ov, zero, ones, eq, err
   );

   modport slave (
      input  start, op, a, b, ci, com, use_acc,
      output ready, y, y_hi, done, co, ov, zero, ones, eq, err
   );
endinterface

// File: rtl/xalu_seq.sv
// WIDTH-bit sequential ALU with accumulator, status flags and start/done handshake.
// Define XALU_MUL_EN to build the iterative shift-add multiplier behind op 11.
module xalu_seq #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
   input  logic      clk,
   input  logic      rst_n,
   xalu_seq_if.slave bus
);
   localparam int SW = $clog2(WIDTH);
   localparam int CW = SW + 1;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_PASSA = 4'd4;
   localparam logic [3:0] OP_PASSB = 4'd5;
   localparam logic [3:0] OP_SHR1  = 4'd6;
   localparam logic [3:0] OP_SHL1  = 4'd7;
   localparam logic [3:0] OP_SUB   = 4'd8;
   localparam logic [3:0] OP_SHLN  = 4'd9;
   localparam logic [3:0] OP_SHRN  = 4'd10;
   localparam logic [3:0] OP_MUL   = 4'd11;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t state, state_nxt;

   function automatic logic is_mul_op(input logic [3:0] op);
`ifdef XALU_MUL_EN
      return op == OP_MUL;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic is_iter(input logic [3:0] op);
      return (op == OP_SHLN) || (op == OP_SHRN) || is_mul_op(op);
   endfunction

   function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                    input logic signed [WIDTH-1:0] z,
                                    input logic signed [WIDTH-1:0] s);
      return (x[WIDTH-1] == z[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
   endfunction

   logic [3:0]       op_p0;
   logic [WIDTH-1:0] a_p0, b_p0;
   logic             ci_p0, com_p0;
   logic [SW-1:0]    amt_p0;
   logic [WIDTH-1:0] lo_p1, hi_p1;
   logic             co_p1;
   logic [CW-1:0]    cnt_p1;
   logic [WIDTH-1:0] acc, a_sel;
   logic             accept;

   logic [WIDTH-1:0] y_p2, y_hi_p2;
   logic             vld_p2, co_p2, ov_p2, zero_p2, ones_p2, eq_p2, err_p2;

   assign a_sel  = bus.use_acc ? acc : bus.a;
   assign accept = (state == IDLE) && bus.start;
   assign amt_p0 = b_p0[SW-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = is_iter(bus.op) ? RUN : FIN;
         RUN:     if (cnt_p1 == CW'(1)) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef XALU_MUL_EN
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, a_p0} : '0);
`endif

   // p0 capture on accept; p1 iterative shift/multiply working registers
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0  <= bus.op;
         a_p0   <= a_sel;
         b_p0   <= bus.b;
         ci_p0  <= bus.ci;
         com_p0 <= bus.com;
         lo_p1  <= is_mul_op(bus.op) ? bus.b : a_sel;
         hi_p1  <= '0;
         co_p1  <= 1'b0;
         if (is_mul_op(bus.op))            cnt_p1 <= CW'(WIDTH);
         else if (bus.b[SW-1:0] == '0)     cnt_p1 <= CW'(1);
         else                              cnt_p1 <= CW'(bus.b[SW-1:0]);
      end else if (state == RUN) begin
         cnt_p1 <= cnt_p1 - 1'b1;
         // amt=0 still spends one RUN cycle but leaves A untouched
         if (op_p0 == OP_SHLN && amt_p0 != '0)      {co_p1, lo_p1} <= {lo_p1, 1'b0};
         else if (op_p0 == OP_SHRN && amt_p0 != '0) {lo_p1, co_p1} <= {1'b0, lo_p1};
`ifdef XALU_MUL_EN
         else if (op_p0 == OP_MUL)                  {hi_p1, lo_p1} <= {mul_sum, lo_p1[WIDTH-1:1]};
`endif
      end
   end

   logic [WIDTH-1:0] b_eff, r, y_nxt, y_hi_nxt;
   logic [WIDTH:0]   sum;
   logic             co_nxt, ov_nxt, err_nxt;

   always_comb begin
      b_eff    = (op_p0 == OP_SUB) ? ~b_p0 : b_p0;
      sum      = {1'b0, a_p0} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci_p0};
      r        = '0;
      y_hi_nxt = '0;
      co_nxt   = 1'b0;
      ov_nxt   = 1'b0;
      err_nxt  = 1'b0;
      case (op_p0)
         OP_ADD, OP_SUB: begin
            r      = sum[WIDTH-1:0];
            co_nxt = sum[WIDTH];
            ov_nxt = add_ovf(a_p0, b_eff, sum[WIDTH-1:0]);
         end
         OP_AND:   r = a_p0 & b_p0;
         OP_OR:    r = a_p0 | b_p0;
         OP_XOR:   r = a_p0 ^ b_p0;
         OP_PASSA: r = a_p0;
         OP_PASSB: r = b_p0;
         OP_SHR1: begin
            r      = {ci_p0, a_p0[WIDTH-1:1]};
            co_nxt = a_p0[0];
         end
         OP_SHL1: begin
            r      = {a_p0[WIDTH-2:0], ci_p0};
            co_nxt = a_p0[WIDTH-1];
         end
         OP_SHLN, OP_SHRN: begin
            r      = lo_p1;
            co_nxt = co_p1;
         end
`ifdef XALU_MUL_EN
         OP_MUL: begin
            r        = lo_p1;
            y_hi_nxt = hi_p1;
         end
`endif
         default: err_nxt = 1'b1;
      endcase
      y_nxt = r ^ {WIDTH{com_p0}};
   end

   // p2 result/flag registers, loaded only in FIN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_p2    <= '0;
         y_hi_p2 <= '0;
         vld_p2  <= 1'b0;
         co_p2   <= 1'b0;
         ov_p2   <= 1'b0;
         zero_p2 <= 1'b1;
         ones_p2 <= 1'b0;
         eq_p2   <= 1'b0;
         err_p2  <= 1'b0;
         acc     <= ACC_INIT;
      end else begin
         vld_p2 <= (state == FIN);
         if (state == FIN) begin
            y_p2    <= y_nxt;
            y_hi_p2 <= y_hi_nxt;
            co_p2   <= co_nxt;
            ov_p2   <= ov_nxt;
            zero_p2 <= (y_nxt == '0);
            ones_p2 <= &y_nxt;
            eq_p2   <= (a_p0 == b_p0);
            err_p2  <= err_nxt;
            acc     <= y_nxt;
         end
      end
   end

   assign bus.ready = (state == IDLE);
   assign bus.y     = y_p2;
   assign bus.y_hi  = y_hi_p2;
   assign bus.done  = vld_p2;
   assign bus.co    = co_p2;
   assign bus.ov    = ov_p2;
   assign bus.zero  = zero_p2;
   assign bus.ones  = ones_p2;
   assign bus.eq    = eq_p2;
   assign bus.err   = err_p2;
endmodule

// File: tb/tb_xalu_seq.sv
// Randomized self-checking bench for xalu_seq against an arithmetic reference model.
module tb_xalu_seq;
   localparam int W = 8;
   localparam logic [W-1:0] ACC_INIT = 8'h5A;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   logic [W-1:0] acc_m;

   xalu_seq_if #(.WIDTH(W)) bus ();

   xalu_seq #(.WIDTH(W), .ACC_INIT(ACC_INIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v);
      return (v >= (longint'(1) << (W-1))) ? v - (longint'(1) << W) : v;
   endfunction

   task automatic model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit ci, input bit com,
                        output longint ey, output longint eyhi, output bit eco,
                        output bit eov, output bit eerr, output int elat);
      longint A, B, M, r, s, ss;
      int amt;
      A = longint'(av);
      B = longint'(bv);
      M = (longint'(1) << W) - 1;
      amt = int'(bv) % W;
      r = 0; eyhi = 0; eco = 0; eov = 0; eerr = 0; elat = 1;
      case (op)
         4'd0, 4'd8: begin
            if (op == 4'd8) B = (~B) & M;
            s   = A + B + longint'(ci);
            r   = s & M;
            eco = (s > M);
            ss  = sx(A) + sx(B) + longint'(ci);
            eov = (ss > (longint'(1) << (W-1)) - 1) || (ss < -(longint'(1) << (W-1)));
         end
         4'd1: r = A & B;
         4'd2: r = A | B;
         4'd3: r = A ^ B;
         4'd4: r = A;
         4'd5: r = B;
         4'd6: begin r = (A >> 1) | (longint'(ci) << (W-1)); eco = (A & 1) != 0; end
         4'd7: begin r = ((A << 1) | longint'(ci)) & M; eco = ((A >> (W-1)) & 1) != 0; end
         4'd9: begin
            r    = (A << amt) & M;
            eco  = (amt != 0) && (((A >> (W-amt)) & 1) != 0);
            elat = ((amt == 0) ? 1 : amt) + 1;
         end
         4'd10: begin
            r    = A >> amt;
            eco  = (amt != 0) && (((A >> (amt-1)) & 1) != 0);
            elat = ((amt == 0) ? 1 : amt) + 1;
         end
`ifdef XALU_MUL_EN
         4'd11: begin
            s    = A * B;
            r    = s & M;
            eyhi = (s >> W) & M;
            elat = W + 1;
         end
`endif
         default: eerr = 1;
      endcase
      ey = com ? (r ^ M) : r;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit ci, input bit com, input bit use_acc, input bit gap);
      longint ey, eyhi;
      bit eco, eov, eerr;
      int elat, lat, busy, t;
      logic [W-1:0] aop;
      aop = use_acc ? acc_m : av;
      model(op, aop, bv, ci, com, ey, eyhi, eco, eov, eerr, elat);
      t = 0;
      while (!bus.ready && t < 200) begin @(negedge clk); t++; end
      check("ready_wait", 64'(bus.ready), 64'(1));
      bus.op = op; bus.a = av; bus.b = bv; bus.ci = ci; bus.com = com;
      bus.use_acc = use_acc; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      busy = bus.ready ? 0 : 1;
      lat  = 0;
      while (lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.done) break;
         if (!bus.ready) busy++;
      end
      check("done", 64'(bus.done), 64'(1));
      check("latency", 64'(lat), 64'(elat));
      check("busy", 64'(busy), 64'(elat));
      check("y", 64'(bus.y), 64'(ey));
      check("y_hi", 64'(bus.y_hi), 64'(eyhi));
      check("co", 64'(bus.co), 64'(eco));
      check("ov", 64'(bus.ov), 64'(eov));
      check("zero", 64'(bus.zero), 64'(ey == 0));
      check("ones", 64'(bus.ones), 64'(ey == (longint'(1) << W) - 1));
      check("eq", 64'(bus.eq), 64'(aop == bv));
      check("err", 64'(bus.err), 64'(eerr));
      acc_m = W'(ey);
      if (gap) begin
         @(negedge clk);
         check("done_pulse", 64'(bus.done), 64'(0));
         check("y_hold", 64'(bus.y), 64'(ey));
      end
   endtask

   initial begin
      bit seen;
      n_checks = 0; n_fail = 0;
      acc_m = ACC_INIT;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      bus.ci = 1'b0; bus.com = 1'b0; bus.use_acc = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(bus.ready), 64'(1));
      check("rst_y", 64'(bus.y), 64'(0));
      check("rst_y_hi", 64'(bus.y_hi), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_co", 64'(bus.co), 64'(0));
      check("rst_ov", 64'(bus.ov), 64'(0));
      check("rst_zero", 64'(bus.zero), 64'(1));
      check("rst_ones", 64'(bus.ones), 64'(0));
      check("rst_eq", 64'(bus.eq), 64'(0));
      check("rst_err", 64'(bus.err), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      run_op(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(4'd8, 8'h05, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(4'd4, 8'h33, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      run_op(4'd9, 8'h81, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(4'd10, 8'h81, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(4'd11, 8'h0F, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(4'd13, 8'hAA, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(4'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(4'd11, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);

      // abort a long shift with reset while start stays asserted
      bus.op = 4'd9; bus.a = 8'h3C; bus.b = 8'h07; bus.ci = 1'b0;
      bus.com = 1'b0; bus.use_acc = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         seen |= bus.done;
         check("abort_busy", 64'(bus.ready), 64'(0));
      end
      rst_n = 1'b0;
      @(negedge clk);
      seen |= bus.done;
      check("abort_ready", 64'(bus.ready), 64'(1));
      check("abort_y", 64'(bus.y), 64'(0));
      check("abort_zero", 64'(bus.zero), 64'(1));
      check("abort_no_done", 64'(seen), 64'(0));
      rst_n = 1'b1;
      bus.start = 1'b0;
      acc_m = ACC_INIT;
      @(negedge clk);
      run_op(4'd4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 250; i++) begin
         run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/xalu_seq.md
Name: xalu_seq

Overview:
- WIDTH-bit sequential ALU; parametrised successor of the 4-bit combinational ALU slice.
- Keeps opcodes 0-7 (ADD, AND, OR, XOR, PASSA, PASSB, SHR1, SHL1) and the complement-output mode.
- Adds registered result, status flags, an accumulator for operand chaining, start/done handshake, subtract, iterative multi-bit shifts and an optional iterative multiplier.
- Sits between the pin-level wrapper and datapath registers in the next ALU tile.

Parameters:
WIDTH, 8, datapath width; legal 4..32. SW = clog2(WIDTH) is derived internally and is not overridable.
ACC_INIT, 0, accumulator value after reset.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  operation request; accepted only when ready=1
ready  output  1  1 in IDLE
op  input  4  function code, captured on accept
a  input  WIDTH  operand A
b  input  WIDTH  operand B; shift amount is b[SW-1:0]
ci  input  1  carry/shift-in, captured on accept
com  input  1  complement output mode, captured on accept
use_acc  input  1  1: operand A = accumulator instead of a
y  output  WIDTH  registered result
y_hi  output  WIDTH  upper product half for MUL; 0 for all other ops
done  output  1  one-cycle pulse when y and flags update
co  output  1  carry/bit shifted out
ov  output  1  signed overflow for ADD/SUB; 0 otherwise
zero  output  1  y == 0
ones  output  1  y all ones (negative zero)
eq  output  1  captured A == captured B
err  output  1  reserved/disabled opcode

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: state=IDLE, ready=1, y=0, y_hi=0, done=0, co=0, ov=0, zero=1, ones=0, eq=0, err=0, acc=ACC_INIT. Reset mid-operation aborts the operation: no done pulse, acc is not updated.
- FSM states: IDLE, RUN, FIN.
  - IDLE & start: capture op, A (acc if use_acc, else a), b, ci, com; go to RUN, except single-cycle ops, which go to FIN.
  - RUN: one step per cycle; go to FIN when the step counter reaches its terminal count.
  - FIN: register y/flags, pulse done, update acc, return to IDLE.
  - start outside IDLE is ignored (ready=0).
- Latency, measured from the accepting edge to the done edge:
  - 1 cycle for ops 0-8, 12-15.
  - max(1, amt)+1 cycles for SHLN/SHRN.
  - WIDTH+1 cycles for MUL.
- Opcodes; r is the pre-complement result:
  - 0 ADD: r = A+B+ci; co = carry out.
  - 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB: co = 0.
  - 6 SHR1: r = {ci, A[W-1:1]}; co = A[0].
  - 7 SHL1: r = {A[W-2:0], ci}; co = A[W-1].
  - 8 SUB: r = A + ~B + ci (ci=1 gives a true difference); co = no-borrow.
  - 9 SHLN: shift left one bit per cycle, amt = b[SW-1:0] times, zero fill; co = last bit out. amt=0 gives r=A, co=0.
  - 10 SHRN: as SHLN, logical right shift.
  - 11 MUL: unsigned shift-add, one partial product per cycle; {y_hi, r} = A*B; co = 0.
  - 12-15: r = 0, err = 1.
- Output and flags:
  - y = r XOR {WIDTH{com}}.
  - zero/ones are evaluated on the final y; y_hi is never complemented.
  - ov = sign overflow of the ADD/SUB result before complement.
  - acc <= y on every done.
  - All outputs hold their value until the next done or reset.
- Back-to-back: start may be high in the same cycle done pulses, but it is only accepted once ready=1, i.e. on the following edge.

Optional Feature:
XALU_MUL_EN
- Defined: op 11 runs the iterative multiplier as specified above.
- Undefined: multiplier logic is absent; op 11 behaves as a reserved opcode (1-cycle, r=0, y_hi=0, err=1).

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 ci=0 -> done 1 cycle after accept, y=0x80, co=0, ov=1, zero=0.
- SUB a=0x05 b=0x05 ci=1 -> y=0x00, zero=1, co=1, eq=1, ov=0; then use_acc=1, PASSA com=1 -> y=0xFF, ones=1.
- SHLN a=0x81 b=0x03 -> ready low 4 cycles, y=0x08, co=0; SHRN a=0x81 b=0x00 -> latency 2, y=0x81, co=0.
- MUL a=0x0F b=0x11 with XALU_MUL_EN -> latency 9, y=0xFF, y_hi=0x00; without the macro -> latency 1, y=0x00, err=1.
- SHLN b=0x07, start held high throughout busy, rst_n=0 at accept+3 -> next edge ready=1, y=0, zero=1, no done pulse, acc=ACC_INIT.
- Op 13 -> y=0x00, err=1; following ADD 0x01+0x01 -> err=0, y=0x02.
